// File: rtl/aes_cbc_enc.sv
// aes_cbc_enc: CBC chaining controller in front of an AES-128 encrypt core.
// Ports:
//   iClk, iRst           clock, synchronous active-high reset
//   iIvLoad, iIv         IV load pulse and 128-bit initialisation vector
//   iPtValid/oPtReady    plaintext stream handshake; iPtData, iPtLast payload
//   oAesStart/iAesReady  block issue to the core; oAesData = plaintext ^ chain
//   iAesValid, iAesData  core result pulse and ciphertext
//   iCtReady/oCtValid    ciphertext stream handshake; oCtData, oCtLast payload
//   oBlkCnt              saturating count of blocks delivered since IV load
//   oErr                 sticky core-timeout error, cleared by IV load
module aes_cbc_enc #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iIvLoad,
  input  logic [127:0]     iIv,
  input  logic             iPtValid,
  output logic             oPtReady,
  input  logic [127:0]     iPtData,
  input  logic             iPtLast,
  output logic             oAesStart,
  output logic [127:0]     oAesData,
  input  logic             iAesReady,
  input  logic             iAesValid,
  input  logic [127:0]     iAesData,
  output logic             oCtValid,
  input  logic             iCtReady,
  output logic [127:0]     oCtData,
  output logic             oCtLast,
  output logic [CNT_W-1:0] oBlkCnt,
  output logic             oErr
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_NOIV,
    S_READY,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       aes_data_q, aes_data_d;
  logic [127:0]       ct_data_q, ct_data_d;
  logic               ct_last_q, ct_last_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    aes_data_d = aes_data_q;
    ct_data_d  = ct_data_q;
    ct_last_d  = ct_last_q;
    last_d     = last_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    oPtReady   = 1'b0;

    case (state_q)
      S_NOIV: begin
        if (iIvLoad) begin
          chain_d = iIv;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_READY;
        end
      end
      S_READY: begin
        // IV load takes priority: plaintext is refused in the same cycle
        oPtReady = !iIvLoad;
        if (iIvLoad) begin
          chain_d = iIv;
          cnt_d   = '0;
        end else if (iPtValid) begin
          aes_data_d = iPtData ^ chain_q;
          last_d     = iPtLast;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (iAesReady) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iAesValid) begin
          chain_d   = iAesData;
          ct_data_d = iAesData;
          ct_last_d = last_q;
          state_d   = S_OUT;
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = S_NOIV;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT: begin
        if (iCtReady) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = ct_last_q ? S_NOIV : S_READY;
        end
      end
      default: state_d = S_NOIV;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_NOIV;
      chain_q    <= '0;
      aes_data_q <= '0;
      ct_data_q  <= '0;
      ct_last_q  <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      aes_data_q <= aes_data_d;
      ct_data_q  <= ct_data_d;
      ct_last_q  <= ct_last_d;
      last_q     <= last_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign oAesStart = (state_q == S_ISSUE);
  assign oCtValid  = (state_q == S_OUT);
  assign oAesData  = aes_data_q;
  assign oCtData   = ct_data_q;
  assign oCtLast   = ct_last_q;
  assign oBlkCnt   = cnt_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_aes_cbc_enc.sv
// Directed bench for aes_cbc_enc; the bench itself plays the AES core.
module tb_aes_cbc_enc;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic             iClk;
  logic             iRst;
  logic             iIvLoad;
  logic [127:0]     iIv;
  logic             iPtValid;
  logic             oPtReady;
  logic [127:0]     iPtData;
  logic             iPtLast;
  logic             oAesStart;
  logic [127:0]     oAesData;
  logic             iAesReady;
  logic             iAesValid;
  logic [127:0]     iAesData;
  logic             oCtValid;
  logic             iCtReady;
  logic [127:0]     oCtData;
  logic             oCtLast;
  logic [CNT_W-1:0] oBlkCnt;
  logic             oErr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] X1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] X2  = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] IV2 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] IV3 = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] PT3 = 128'h00ff00ff00ff00ff00ff00ff00ff00ff;
  localparam logic [127:0] X3  = 128'h0ff00ff00ff00ff00ff00ff00ff00ff0;

  aes_cbc_enc #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iIvLoad  (iIvLoad),
    .iIv      (iIv),
    .iPtValid (iPtValid),
    .oPtReady (oPtReady),
    .iPtData  (iPtData),
    .iPtLast  (iPtLast),
    .oAesStart(oAesStart),
    .oAesData (oAesData),
    .iAesReady(iAesReady),
    .iAesValid(iAesValid),
    .iAesData (iAesData),
    .oCtValid (oCtValid),
    .iCtReady (iCtReady),
    .oCtData  (oCtData),
    .oCtLast  (oCtLast),
    .oBlkCnt  (oBlkCnt),
    .oErr     (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    iRst = 1'b1; iIvLoad = 1'b0; iIv = '0; iPtValid = 1'b0; iPtData = '0;
    iPtLast = 1'b0; iAesReady = 1'b0; iAesValid = 1'b0; iAesData = '0; iCtReady = 1'b0;

    tick(); tick();
    chk("rst_ptready", 128'(oPtReady), 128'd0);
    chk("rst_aesstart", 128'(oAesStart), 128'd0);
    chk("rst_aesdata", oAesData, '0);
    chk("rst_ctvalid", 128'(oCtValid), 128'd0);
    chk("rst_ctdata", oCtData, '0);
    chk("rst_ctlast", 128'(oCtLast), 128'd0);
    chk("rst_blkcnt", 128'(oBlkCnt), 128'd0);
    chk("rst_err", 128'(oErr), 128'd0);

    // NOIV refuses plaintext
    iRst = 1'b0; iPtValid = 1'b1; iPtData = PT1;
    #1 chk("noiv_ptready", 128'(oPtReady), 128'd0);
    tick();
    chk("noiv_no_issue", 128'(oAesStart), 128'd0);

    // IV load, then first block
    iPtValid = 1'b0; iIvLoad = 1'b1; iIv = IV1;
    tick();
    iIvLoad = 1'b0; iPtValid = 1'b1; iPtData = PT1; iPtLast = 1'b0;
    #1 chk("ready_ptready", 128'(oPtReady), 128'd1);
    tick();
    iPtValid = 1'b0;
    chk("b1_aesstart", 128'(oAesStart), 128'd1);
    chk("b1_aesdata", oAesData, X1);
    chk("b1_ptready_busy", 128'(oPtReady), 128'd0);
    tick();
    chk("b1_start_held", 128'(oAesStart), 128'd1);
    iAesReady = 1'b1;
    tick();
    iAesReady = 1'b0;
    chk("b1_wait_nostart", 128'(oAesStart), 128'd0);
    chk("b1_wait_noct", 128'(oCtValid), 128'd0);
    tick();
    iAesValid = 1'b1; iAesData = CT1;
    tick();
    iAesValid = 1'b0;
    chk("b1_ctvalid", 128'(oCtValid), 128'd1);
    chk("b1_ctdata", oCtData, CT1);
    chk("b1_ctlast", 128'(oCtLast), 128'd0);
    chk("b1_cnt_pre", 128'(oBlkCnt), 128'd0);

    // Downstream backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ctvalid", 128'(oCtValid), 128'd1);
      chk("bp_ctdata", oCtData, CT1);
      chk("bp_ptready", 128'(oPtReady), 128'd0);
      chk("bp_cnt", 128'(oBlkCnt), 128'd0);
    end
    iCtReady = 1'b1;
    tick();
    iCtReady = 1'b0;
    chk("b1_cnt_post", 128'(oBlkCnt), 128'd1);
    chk("b1_ct_dropped", 128'(oCtValid), 128'd0);
    chk("b1_ready_again", 128'(oPtReady), 128'd1);

    // Second block chains on CT1, marked last
    iPtValid = 1'b1; iPtData = PT2; iPtLast = 1'b1;
    tick();
    iPtValid = 1'b0; iPtLast = 1'b0;
    chk("b2_aesdata", oAesData, X2);
    iAesReady = 1'b1;
    tick();
    iAesReady = 1'b0; iAesValid = 1'b1; iAesData = CT2;
    tick();
    iAesValid = 1'b0;
    chk("b2_ctdata", oCtData, CT2);
    chk("b2_ctlast", 128'(oCtLast), 128'd1);
    iCtReady = 1'b1;
    tick();
    iCtReady = 1'b0;
    chk("b2_cnt", 128'(oBlkCnt), 128'd2);
    chk("b2_noiv_ptready", 128'(oPtReady), 128'd0);
    iPtValid = 1'b1; iPtData = PT3;
    tick();
    chk("b2_noiv_no_issue", 128'(oAesStart), 128'd0);

    // New IV clears the count
    iIvLoad = 1'b1; iIv = IV2;
    tick();
    chk("iv2_cnt_clear", 128'(oBlkCnt), 128'd0);

    // IV load and plaintext in the same READY cycle
    iIv = IV3;
    #1 chk("ivpt_ptready", 128'(oPtReady), 128'd0);
    tick();
    chk("ivpt_not_accepted", 128'(oAesStart), 128'd0);
    iIvLoad = 1'b0;
    #1 chk("ivpt_ready_after", 128'(oPtReady), 128'd1);
    tick();
    iPtValid = 1'b0;
    chk("ivpt_new_iv_used", oAesData, X3);

    // Core never answers: timeout
    iAesReady = 1'b1;
    tick();
    iAesReady = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("tmo_no_ct", 128'(oCtValid), 128'd0);
    end
    chk("tmo_err_early", 128'(oErr), 128'd0);
    tick();
    chk("tmo_err_set", 128'(oErr), 128'd1);
    chk("tmo_ptready", 128'(oPtReady), 128'd0);
    iAesValid = 1'b1; iAesData = CT1;
    tick();
    iAesValid = 1'b0;
    chk("tmo_late_ignored", 128'(oCtValid), 128'd0);
    chk("tmo_err_sticky", 128'(oErr), 128'd1);
    iIvLoad = 1'b1; iIv = '0;
    tick();
    iIvLoad = 1'b0;
    chk("tmo_err_clear", 128'(oErr), 128'd0);
    #1 chk("tmo_ready", 128'(oPtReady), 128'd1);

    // Reset while waiting on the core
    iPtValid = 1'b1; iPtData = 128'h1;
    tick();
    iPtValid = 1'b0;
    chk("rw_aesdata", oAesData, 128'h1);
    iAesReady = 1'b1;
    tick();
    iAesReady = 1'b0; iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("rw_aesdata_rst", oAesData, '0);
    chk("rw_aesstart_rst", 128'(oAesStart), 128'd0);
    chk("rw_ctdata_rst", oCtData, '0);
    chk("rw_ctlast_rst", 128'(oCtLast), 128'd0);
    chk("rw_ptready_rst", 128'(oPtReady), 128'd0);
    iAesValid = 1'b1; iAesData = CT2;
    tick();
    iAesValid = 1'b0;
    chk("rw_late_ctvalid", 128'(oCtValid), 128'd0);
    tick();
    chk("rw_late_ctvalid2", 128'(oCtValid), 128'd0);
    chk("rw_ctdata_hold", oCtData, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
